// File: rtl/move_key_encoder_pkg.sv
// rtl/move_key_encoder_pkg.sv - scan-code constants, prefix states and key map for move_key_encoder
package move_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_e;

  localparam logic [7:0] SC_EXT        = 8'hE0;
  localparam logic [7:0] SC_BRK        = 8'hF0;
  localparam logic [7:0] SC_W          = 8'h1D;
  localparam logic [7:0] SC_A          = 8'h1C;
  localparam logic [7:0] SC_S          = 8'h1B;
  localparam logic [7:0] SC_D          = 8'h23;
  localparam logic [7:0] SC_P          = 8'h4D;
  localparam logic [7:0] SC_ENTER      = 8'h5A;
  localparam logic [7:0] SC_ARR_UP     = 8'h75;
  localparam logic [7:0] SC_ARR_DOWN   = 8'h72;
  localparam logic [7:0] SC_ARR_LEFT   = 8'h6B;
  localparam logic [7:0] SC_ARR_RIGHT  = 8'h74;

  localparam int MV_RIGHT = 0;
  localparam int MV_LEFT  = 1;
  localparam int MV_DOWN  = 2;
  localparam int MV_UP    = 3;

  // Held bitmap: [3:0] WASD keys, [7:4] arrow keys, both ordered by MV_* index.
  localparam int ARR_OFS = 4;

  // One-hot position of a tracked direction key in the held bitmap; zero when
  // the code (or its extended flag) does not belong to a tracked key.
  function automatic logic [7:0] key_onehot(input logic [7:0] key, input logic ext);
    logic [7:0] oh;
    oh = '0;
    if (!ext) begin
      case (key)
        SC_D:    oh[MV_RIGHT] = 1'b1;
        SC_A:    oh[MV_LEFT]  = 1'b1;
        SC_S:    oh[MV_DOWN]  = 1'b1;
        SC_W:    oh[MV_UP]    = 1'b1;
        default: oh = '0;
      endcase
    end else begin
      case (key)
        SC_ARR_RIGHT: oh[ARR_OFS+MV_RIGHT] = 1'b1;
        SC_ARR_LEFT:  oh[ARR_OFS+MV_LEFT]  = 1'b1;
        SC_ARR_DOWN:  oh[ARR_OFS+MV_DOWN]  = 1'b1;
        SC_ARR_UP:    oh[ARR_OFS+MV_UP]    = 1'b1;
        default:      oh = '0;
      endcase
    end
    return oh;
  endfunction

endpackage

// File: rtl/move_key_encoder_if.sv
// rtl/move_key_encoder_if.sv - scan-code input and movement/control outputs of move_key_encoder
interface move_key_encoder_if;
  logic       code_valid;
  logic [7:0] code;
  logic [3:0] move_opr;
  logic       pause;
  logic       start_pulse;

  modport master (
    output code_valid,
    output code,
    input  move_opr,
    input  pause,
    input  start_pulse
  );

  modport slave (
    input  code_valid,
    input  code,
    output move_opr,
    output pause,
    output start_pulse
  );
endinterface

// File: rtl/move_key_encoder_scan_prefix_fsm.sv
// rtl/move_key_encoder_scan_prefix_fsm.sv - E0/F0 prefix tracker with abandon timeout
module scan_prefix_fsm
  import move_key_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       code_valid,
  input  logic [7:0] code,
  output logic       make_stb,
  output logic       brk_stb,
  output logic       ext,
  output logic [7:0] key
);

  localparam int              CW       = $clog2(PREFIX_TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(PREFIX_TIMEOUT - 1);

  prefix_state_e state;
  logic [CW-1:0] cnt;
  logic          is_prefix;

  assign is_prefix = (code == SC_EXT) || (code == SC_BRK);

  // Prefix state and timeout counter; an arriving byte always beats an expiring timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (code_valid) begin
      cnt <= '0;
      case (state)
        ST_IDLE: begin
          if (code == SC_EXT)      state <= ST_EXT;
          else if (code == SC_BRK) state <= ST_BRK;
          else                     state <= ST_IDLE;
        end
        ST_EXT: begin
          if (code == SC_BRK)      state <= ST_EXT_BRK;
          else if (code == SC_EXT) state <= ST_EXT;
          else                     state <= ST_IDLE;
        end
        ST_BRK: begin
          if (code == SC_EXT)      state <= ST_EXT_BRK;
          else if (code == SC_BRK) state <= ST_BRK;
          else                     state <= ST_IDLE;
        end
        default: begin
          if (is_prefix) state <= ST_EXT_BRK;
          else           state <= ST_IDLE;
        end
      endcase
    end else if (state != ST_IDLE) begin
      if (cnt == CNT_LAST) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Final-byte decode in the current prefix state, so the top can register the result
  // in the same cycle the byte is sampled.
  always_comb begin
    make_stb = 1'b0;
    brk_stb  = 1'b0;
    ext      = 1'b0;
    key      = code;
    if (code_valid && !is_prefix) begin
      case (state)
        ST_IDLE: make_stb = 1'b1;
        ST_EXT: begin
          make_stb = 1'b1;
          ext      = 1'b1;
        end
        ST_BRK: brk_stb = 1'b1;
        default: begin
          brk_stb = 1'b1;
          ext     = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/move_key_encoder.sv
// rtl/move_key_encoder.sv - PS/2 scan codes to held move_opr, pause toggle and start pulse
module move_key_encoder
  import move_key_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  move_key_encoder_if.slave    kb
);

  logic       make_stb;
  logic       brk_stb;
  logic       ext;
  logic [7:0] key;

  logic [7:0] held;
  logic [7:0] held_next;
  logic [7:0] hit;
  logic       p_held;
  logic       ent_held;
  logic       is_p;
  logic       is_ent;

  scan_prefix_fsm #(
    .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
  ) u_prefix (
    .clk        (clk),
    .rst        (rst),
    .code_valid (kb.code_valid),
    .code       (kb.code),
    .make_stb   (make_stb),
    .brk_stb    (brk_stb),
    .ext        (ext),
    .key        (key)
  );

  assign is_p   = (key == SC_P)     && !ext;
  assign is_ent = (key == SC_ENTER) && !ext;

  // Next held bitmap: make sets the key's bit, break clears it, untracked keys change nothing.
  always_comb begin
    hit       = key_onehot(key, ext);
    held_next = held;
    if (make_stb)     held_next = held | hit;
    else if (brk_stb) held_next = held & ~hit;
  end

  // Registered outputs and held flags; P and Enter act only on a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      held           <= '0;
      p_held         <= 1'b0;
      ent_held       <= 1'b0;
      kb.move_opr    <= '0;
      kb.pause       <= 1'b0;
      kb.start_pulse <= 1'b0;
    end else begin
      held           <= held_next;
      kb.move_opr    <= held_next[3:0] | held_next[7:4];
      kb.start_pulse <= make_stb && is_ent && !ent_held;
      if (make_stb && is_p && !p_held) kb.pause <= ~kb.pause;
      if (is_p) begin
        if (make_stb)     p_held <= 1'b1;
        else if (brk_stb) p_held <= 1'b0;
      end
      if (is_ent) begin
        if (make_stb)     ent_held <= 1'b1;
        else if (brk_stb) ent_held <= 1'b0;
      end
    end
  end

endmodule
